// File: rtl/i2c_config_sequencer.sv
// Power-up loader for the codec control registers. Walks the register table and drives the
// I2C bit engine through START / address / high byte / low byte / STOP for each entry.
module i2c_config_sequencer #(
    parameter logic [6:0]  DEV_ADDR    = 7'h1A,
    parameter int unsigned NUM_ENTRIES = 11,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic              inClock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] tblAddr,
    input  logic [15:0]       tblData,
    output logic              phyEn,
    output logic [1:0]        phyMode,
    output logic [7:0]        phyData,
    input  logic              phyReady,
    input  logic              phyAck,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] failIndex
);

    localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ModeStart = 2'd0;
    localparam logic [1:0] ModeByte  = 2'd1;
    localparam logic [1:0] ModeStop  = 2'd2;

    typedef enum logic [3:0] {
        StIdle, StStart, StAddr, StHi, StLo, StStop, StNext, StDone, StError
    } state_t;

    state_t              stateQ, stateD;
    logic [ADDR_W-1:0]   addrQ, addrD;
    logic [RetryW-1:0]   retryQ, retryD;
    logic                pendingQ, pendingD;
    logic                seenLowQ, seenLowD;
    logic [TimerW-1:0]   timerQ, timerD;
    logic                doneQ, doneD;
    logic                errorQ, errorD;
    logic [ADDR_W-1:0]   failQ, failD;
    logic                complete;

    assign complete = seenLowQ & phyReady;

    always_comb begin
        stateD   = stateQ;
        addrD    = addrQ;
        retryD   = retryQ;
        pendingD = pendingQ;
        seenLowD = seenLowQ;
        timerD   = timerQ;
        doneD    = doneQ;
        errorD   = errorQ;
        failD    = failQ;
        phyEn    = 1'b0;
        phyMode  = ModeStart;
        phyData  = 8'h00;
        busy     = 1'b1;

        unique case (stateQ)
            StIdle, StDone, StError: begin
                busy = 1'b0;
                if (start) begin
                    doneD    = 1'b0;
                    errorD   = 1'b0;
                    addrD    = '0;
                    retryD   = '0;
                    pendingD = 1'b0;
                    stateD   = StStart;
                end
            end
            StStart: begin
                phyEn = 1'b1;
                if (complete) stateD = StAddr;
            end
            StAddr, StHi, StLo: begin
                phyEn   = 1'b1;
                phyMode = ModeByte;
                phyData = (stateQ == StAddr) ? {DEV_ADDR, 1'b0} :
                          (stateQ == StHi)   ? tblData[15:8] : tblData[7:0];
                if (complete) begin
                    if (!phyAck) begin
                        pendingD = 1'b1;
                        stateD   = StStop;
                    end else begin
                        stateD = (stateQ == StAddr) ? StHi :
                                 (stateQ == StHi)   ? StLo : StStop;
                    end
                end
            end
            StStop: begin
                phyEn   = 1'b1;
                phyMode = ModeStop;
                if (complete) begin
                    if (!pendingQ) begin
                        stateD = StNext;
                    end else if (retryQ != RetryW'(MAX_RETRY)) begin
                        retryD   = retryQ + RetryW'(1);
                        pendingD = 1'b0;
                        stateD   = StStart;
                    end else begin
                        errorD = 1'b1;
                        failD  = addrQ;
                        stateD = StError;
                    end
                end
            end
            StNext: begin
                if (addrQ == ADDR_W'(NUM_ENTRIES - 1)) begin
                    doneD  = 1'b1;
                    stateD = StDone;
                end else begin
                    addrD  = addrQ + ADDR_W'(1);
                    retryD = '0;
                    stateD = StStart;
                end
            end
            default: stateD = StIdle;
        endcase

        // Handshake bookkeeping shared by every op state; leaving an op rearms it.
        if (!phyEn || (stateD != stateQ)) begin
            seenLowD = 1'b0;
            timerD   = '0;
        end else if (timerQ == TimerW'(TIMEOUT_CYC - 1)) begin
            errorD   = 1'b1;
            failD    = addrQ;
            stateD   = StError;
            seenLowD = 1'b0;
            timerD   = '0;
        end else begin
            timerD = timerQ + TimerW'(1);
            if (!phyReady) seenLowD = 1'b1;
        end
    end

    always_ff @(posedge inClock or posedge reset) begin
        if (reset) begin
            stateQ   <= StIdle;
            addrQ    <= '0;
            retryQ   <= '0;
            pendingQ <= 1'b0;
            seenLowQ <= 1'b0;
            timerQ   <= '0;
            doneQ    <= 1'b0;
            errorQ   <= 1'b0;
            failQ    <= '0;
        end else begin
            stateQ   <= stateD;
            addrQ    <= addrD;
            retryQ   <= retryD;
            pendingQ <= pendingD;
            seenLowQ <= seenLowD;
            timerQ   <= timerD;
            doneQ    <= doneD;
            errorQ   <= errorD;
            failQ    <= failD;
        end
    end

    assign tblAddr   = addrQ;
    assign done      = doneQ;
    assign error     = errorQ;
    assign failIndex = failQ;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: behavioural bit-engine model logging issued ops, checked
// against a queue of expected ops, plus a scenario table and hand-written corner cases.
module tb_i2c_config_sequencer;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned TIMEOUT = 1023;

    logic              inClock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] tblAddr;
    logic [15:0]       tblData;
    logic              phyEn;
    logic [1:0]        phyMode;
    logic [7:0]        phyData;
    logic              phyReady = 1'b1;
    logic              phyAck = 1'b1;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] failIndex;

    i2c_config_sequencer #(
        .DEV_ADDR   (7'h1A),
        .NUM_ENTRIES(3),
        .ADDR_W     (ADDR_W),
        .MAX_RETRY  (3),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .inClock  (inClock),
        .reset    (reset),
        .start    (start),
        .tblAddr  (tblAddr),
        .tblData  (tblData),
        .phyEn    (phyEn),
        .phyMode  (phyMode),
        .phyData  (phyData),
        .phyReady (phyReady),
        .phyAck   (phyAck),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .failIndex(failIndex)
    );

    always #5 inClock = ~inClock;

    function automatic logic [15:0] tblVal(input int idx);
        case (idx)
            0:       return 16'h1E00;
            1:       return 16'h0C10;
            2:       return 16'h1201;
            default: return 16'hDEAD;
        endcase
    endfunction

    always_comb tblData = tblVal(int'(tblAddr));

    // Engine model configuration (written by the test only)
    int cfgNack = 0;
    int cfgIdx = 0;
    bit cfgHang = 1'b0;
    bit engClear = 1'b0;

    // Engine model state (written by the engine only)
    bit         engBusy = 1'b0;
    bit         hung = 1'b0;
    bit         nackUsed = 1'b0;
    bit         ackNow = 1'b1;
    int         engCnt = 0;
    int         byteIdx = 0;
    logic [9:0] actLog [256];
    int         wr = 0;

    // Engine reacts on the falling edge so the DUT samples settled inputs on the rising edge.
    always @(negedge inClock) begin
        if (reset || engClear) begin
            engBusy  = 1'b0;
            hung     = 1'b0;
            nackUsed = 1'b0;
            byteIdx  = 0;
            phyReady = 1'b1;
            phyAck   = 1'b1;
        end else if (engBusy) begin
            if (!hung) begin
                if (engCnt == 0) begin
                    phyReady = 1'b1;
                    phyAck   = ackNow;
                    engBusy  = 1'b0;
                end else begin
                    engCnt = engCnt - 1;
                end
            end
        end else if (phyEn) begin
            actLog[wr % 256] = (phyMode == 2'd1) ? {phyMode, phyData} : {phyMode, 8'h00};
            wr = wr + 1;
            ackNow = 1'b1;
            if (phyMode == 2'd0) begin
                byteIdx = 0;
            end else if (phyMode == 2'd1) begin
                if (cfgHang && byteIdx == 0) hung = 1'b1;
                if (cfgNack == 1 && int'(tblAddr) == cfgIdx && byteIdx == 1 && !nackUsed) begin
                    ackNow   = 1'b0;
                    nackUsed = 1'b1;
                end
                if (cfgNack == 2 && int'(tblAddr) == cfgIdx) ackNow = 1'b0;
                byteIdx = byteIdx + 1;
            end
            engBusy  = 1'b1;
            phyReady = 1'b0;
            engCnt   = $urandom_range(3, 0);
        end
    end

    int         checks = 0;
    int         errors = 0;
    int         rd = 0;
    logic [9:0] expQ [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drain();
        logic [9:0] op;
        while (rd != wr) begin
            op = actLog[rd % 256];
            rd = rd + 1;
            if (expQ.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected op: got %0h expected none", op);
            end else begin
                check("op stream", 32'(op), 32'(expQ.pop_front()));
            end
        end
    endtask

    task automatic tick();
        @(negedge inClock);
        drain();
    endtask

    task automatic pushAttempt(input int e, input int nbytes);
        logic [15:0] d;
        d = tblVal(e);
        expQ.push_back(10'h000);
        if (nbytes >= 1) expQ.push_back({2'b01, 8'h34});
        if (nbytes >= 2) expQ.push_back({2'b01, d[15:8]});
        if (nbytes >= 3) expQ.push_back({2'b01, d[7:0]});
        expQ.push_back(10'h200);
    endtask

    typedef struct {
        int nack;
        int idx;
        bit pulseMid;
        bit expDone;
        bit expError;
        int expFail;
        int expAddr;
    } scen_t;

    scen_t scens [4];

    task automatic clearEngine();
        engClear = 1'b1;
        tick();
        tick();
        engClear = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start busy", 32'(busy), 32'd1);
        check("start clears error", 32'(error), 32'd0);
        check("start clears done", 32'(done), 32'd0);
        check("start tblAddr", 32'(tblAddr), 32'd0);
    endtask

    task automatic runScen(input scen_t s);
        int n;
        cfgNack = s.nack;
        cfgIdx  = s.idx;
        cfgHang = 1'b0;
        clearEngine();
        for (int e = 0; e < 3; e++) begin
            if (s.nack == 1 && e == s.idx) begin
                pushAttempt(e, 2);
                pushAttempt(e, 3);
            end else if (s.nack == 2 && e == s.idx) begin
                repeat (4) pushAttempt(e, 1);
            end else if (!(s.nack == 2 && e > s.idx)) begin
                pushAttempt(e, 3);
            end
        end
        pulseStart();
        n = 0;
        while (busy && n < 20000) begin
            tick();
            n = n + 1;
            start = (s.pulseMid && n == 25);
        end
        start = 1'b0;
        check("run finishes", 32'(n < 20000), 32'd1);
        repeat (6) tick();
        check("end done", 32'(done), 32'(s.expDone));
        check("end error", 32'(error), 32'(s.expError));
        check("end tblAddr", 32'(tblAddr), 32'(s.expAddr));
        check("end phyEn", 32'(phyEn), 32'd0);
        if (s.expError) check("end failIndex", 32'(failIndex), 32'(s.expFail));
        check("ops left over", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int n;
        int bad;
        scens[0] = '{0, 0, 1'b1, 1'b1, 1'b0, 0, 2};
        scens[1] = '{1, 1, 1'b0, 1'b1, 1'b0, 0, 2};
        scens[2] = '{2, 2, 1'b0, 1'b0, 1'b1, 2, 2};
        scens[3] = '{0, 0, 1'b0, 1'b1, 1'b0, 0, 2};

        repeat (2) tick();
        check("reset outputs",
              32'({tblAddr, phyEn, phyMode, phyData, busy, done, error, failIndex}), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) runScen(scens[i]);

        // Engine stalls with phyReady low once the address byte is issued.
        cfgNack = 0;
        cfgHang = 1'b1;
        clearEngine();
        expQ.push_back(10'h000);
        expQ.push_back({2'b01, 8'h34});
        pulseStart();
        n = 0;
        while (!(phyEn && phyMode == 2'd1) && n < 100) begin
            tick();
            n = n + 1;
        end
        check("hang addr op reached", 32'(n < 100), 32'd1);
        n = 0;
        while (!error && n < 2000) begin
            tick();
            n = n + 1;
        end
        check("timeout latency", 32'(n), 32'(TIMEOUT));
        check("timeout failIndex", 32'(failIndex), 32'd0);
        check("timeout done", 32'(done), 32'd0);
        check("timeout busy", 32'(busy), 32'd0);
        bad = 0;
        repeat (10) begin
            tick();
            if (phyEn) bad = bad + 1;
        end
        check("no op after timeout", 32'(bad), 32'd0);
        check("timeout op stream", 32'(expQ.size()), 32'd0);

        // Reset during the low byte of entry 1.
        cfgHang = 1'b0;
        clearEngine();
        for (int e = 0; e < 3; e++) pushAttempt(e, 3);
        pulseStart();
        n = 0;
        while (!(tblAddr == 4'd1 && phyMode == 2'd1 && phyData == 8'h10) && n < 500) begin
            tick();
            n = n + 1;
        end
        check("reached entry 1 low byte", 32'(n < 500), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid-op reset outputs",
              32'({tblAddr, phyEn, phyMode, phyData, busy, done, error, failIndex}), 32'd0);
        tick();
        tick();
        expQ.delete();
        reset = 1'b0;
        tick();
        runScen(scens[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
